// File: rtl/logic_ops_pkg.sv
// ---------------------------------------------------------------------------
// logic_ops_pkg
//   Shared definitions for the logic-slice reduction controller:
//     - op encodings driven on the controller's op port
//     - FSM state encodings for logic_reduce_ctrl
//     - per-op identity fill bit (the value every bit of operand A takes so
//       that folding the first word through a slice returns the word itself)
// ---------------------------------------------------------------------------
package logic_ops_pkg;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Identity fill bits: OR and XOR fold against zero, AND against all-ones.
    // The reserved op discards its result, so zero is as good as anything.
    localparam logic ID_OR   = 1'b0;
    localparam logic ID_AND  = 1'b1;
    localparam logic ID_XOR  = 1'b0;
    localparam logic ID_RSVD = 1'b0;

    function automatic logic id_fill(input logic [1:0] op);
        logic f;
        case (op)
            OP_OR:   f = ID_OR;
            OP_AND:  f = ID_AND;
            OP_XOR:  f = ID_XOR;
            default: f = ID_RSVD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/logic_reduce_sel.sv
// ---------------------------------------------------------------------------
// logic_reduce_sel
//   Combinational steering between the controller and the external logic
//   slices. Chooses operand A (identity of the live op on the first beat,
//   the accumulator afterwards) and picks the slice result for the op in
//   force on this beat.
//
// Ports:
//   first    in  1      beat is the first of a packet (controller idle)
//   op_live  in  2      op presented on the port this cycle
//   op_held  in  2      op captured on the first beat of the packet
//   acc      in  WIDTH  current accumulator
//   or_res   in  WIDTH  OR slice result
//   and_res  in  WIDTH  AND slice result
//   xor_res  in  WIDTH  XOR slice result
//   slice_a  out WIDTH  operand A for the slices
//   result   out WIDTH  selected result (zero for the reserved op)
// ---------------------------------------------------------------------------
module logic_reduce_sel
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             first,
    input  logic [1:0]       op_live,
    input  logic [1:0]       op_held,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] or_res,
    input  logic [WIDTH-1:0] and_res,
    input  logic [WIDTH-1:0] xor_res,
    output logic [WIDTH-1:0] slice_a,
    output logic [WIDTH-1:0] result
);

    logic [1:0] eff_op;

    always_comb begin
        eff_op  = first ? op_live : op_held;
        slice_a = first ? {WIDTH{id_fill(op_live)}} : acc;
        case (eff_op)
            OP_OR:   result = or_res;
            OP_AND:  result = and_res;
            OP_XOR:  result = xor_res;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_reduce_ctrl.sv
// ---------------------------------------------------------------------------
// logic_reduce_ctrl
//   Streams a packet of WIDTH-bit words through the external OR/AND/XOR
//   logic slices, folding each word into an accumulator, then presents the
//   reduced word, the saturating beat count and a reserved-op error flag on
//   an output valid/ready port.
//
// Optional feature: define LOGIC_REDUCE_PARITY_EN to add out_parity, the XOR
// of all bits of out_data.
//
// Ports:
//   clk           in  1      clock, rising edge
//   rst_n         in  1      asynchronous active-low reset
//   op            in  2      00 OR, 01 AND, 10 XOR, 11 reserved; first beat
//   in_valid      in  1      input word valid
//   in_ready      out 1      controller can accept a word
//   in_data       in  WIDTH  operand word
//   in_last       in  1      final word of packet
//   slice_a       out WIDTH  operand A to slices
//   slice_b       out WIDTH  operand B to slices (in_data)
//   slice_or_res  in  WIDTH  OR slice result
//   slice_and_res in  WIDTH  AND slice result
//   slice_xor_res in  WIDTH  XOR slice result
//   out_valid     out 1      reduced result valid
//   out_ready     in  1      downstream accepts result
//   out_data      out WIDTH  reduced result
//   out_count     out CNT_W  words in packet, saturating
//   out_err       out 1      packet used the reserved op
//   out_parity    out 1      XOR of out_data bits (LOGIC_REDUCE_PARITY_EN)
// ---------------------------------------------------------------------------
module logic_reduce_ctrl
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] slice_a,
    output logic [WIDTH-1:0] slice_b,
    input  logic [WIDTH-1:0] slice_or_res,
    input  logic [WIDTH-1:0] slice_and_res,
    input  logic [WIDTH-1:0] slice_xor_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
`ifdef LOGIC_REDUCE_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_p1;
    logic [CNT_W-1:0] count_p1;
    logic             err_p1;
    logic [1:0]       op_p1;
    logic             first;
    logic             accept;
    logic [WIDTH-1:0] result;
`ifdef LOGIC_REDUCE_PARITY_EN
    logic             parity_p1;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Accept is derived from state directly (not from in_ready) so the
    // output block below has no combinational loop through in_ready.
    assign first   = (state_q == ST_IDLE);
    assign accept  = in_valid & rst_n & (state_q != ST_HOLD);
    assign slice_b = in_data;

    logic_reduce_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .first   (first),
        .op_live (op),
        .op_held (op_p1),
        .acc     (acc_p1),
        .or_res  (slice_or_res),
        .and_res (slice_and_res),
        .xor_res (slice_xor_res),
        .slice_a (slice_a),
        .result  (result)
    );

    // ---- stage p1: accumulator, counter, captured op and error ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1    <= '0;
            count_p1  <= '0;
            err_p1    <= 1'b0;
            op_p1     <= OP_OR;
`ifdef LOGIC_REDUCE_PARITY_EN
            parity_p1 <= 1'b0;
`endif
        end else if (accept) begin
            acc_p1    <= result;
`ifdef LOGIC_REDUCE_PARITY_EN
            parity_p1 <= ^result;
`endif
            if (first) begin
                op_p1    <= op;
                count_p1 <= CNT_W'(1);
                err_p1   <= (op == OP_RSVD);
            end else begin
                count_p1 <= sat_inc(count_p1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_count = '0;
        out_err   = 1'b0;
`ifdef LOGIC_REDUCE_PARITY_EN
        out_parity = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = rst_n;
                if (accept) state_d = in_last ? ST_HOLD : ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = rst_n;
                if (accept && in_last) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // in_ready stays low: the out_ready cycle never accepts.
                out_valid = 1'b1;
                out_data  = acc_p1;
                out_count = count_p1;
                out_err   = err_p1;
`ifdef LOGIC_REDUCE_PARITY_EN
                out_parity = parity_p1;
`endif
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_logic_reduce_ctrl.sv
module tb_logic_reduce_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_or_res;
    logic [WIDTH-1:0] slice_and_res;
    logic [WIDTH-1:0] slice_xor_res;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
`ifdef LOGIC_REDUCE_PARITY_EN
    logic             out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // The combinational logic slices the controller drives.
    assign slice_or_res  = slice_a | slice_b;
    assign slice_and_res = slice_a & slice_b;
    assign slice_xor_res = slice_a ^ slice_b;

    logic_reduce_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .slice_a       (slice_a),
        .slice_b       (slice_b),
        .slice_or_res  (slice_or_res),
        .slice_and_res (slice_and_res),
        .slice_xor_res (slice_xor_res),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_err       (out_err)
`ifdef LOGIC_REDUCE_PARITY_EN
        ,
        .out_parity    (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reduce a whole packet from the op's definition.
    function automatic logic [WIDTH-1:0] ref_reduce(input logic [1:0] o, input logic [WIDTH-1:0] w[$]);
        logic [WIDTH-1:0] r;
        case (o)
            2'b00: begin r = '0; foreach (w[i]) r = r | w[i]; end
            2'b01: begin r = '1; foreach (w[i]) r = r & w[i]; end
            2'b10: begin r = '0; foreach (w[i]) r = r ^ w[i]; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_count(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Stimulus only: idle for gap cycles, then present one beat for one edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic l, input logic [1:0] o, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_last = l; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #3;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0 || out_count !== 8'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h cnt=%0d err=%b, want 0 0 0 0 0",
                     in_ready, out_valid, out_data, out_count, out_err);
        end
`ifdef LOGIC_REDUCE_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        op = 2'b01; #1;
        n_checks++;
        if (slice_a !== 4'b1111) begin n_fail++; $display("FAIL idle_id_and: got %b want 1111", slice_a); end
        op = 2'b10; #1;
        n_checks++;
        if (slice_a !== 4'b0000) begin n_fail++; $display("FAIL idle_id_xor: got %b want 0000", slice_a); end
        op = 2'b00;
    endtask

    task automatic test_or_packet();
        out_ready = 1'b1;
        send(4'b0001, 1'b0, 2'b00, 0);
        send(4'b0100, 1'b0, 2'b00, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL or_early_valid: got %b want 0", out_valid); end
        send(4'b1000, 1'b1, 2'b00, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1101 || out_count !== 8'd3 || out_err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL or_result: got vld=%b data=%b cnt=%0d err=%b rdy=%b, want 1 1101 3 0 0",
                     out_valid, out_data, out_count, out_err, in_ready);
        end
`ifdef LOGIC_REDUCE_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b1) begin n_fail++; $display("FAIL or_parity: got %b want 1", out_parity); end
`endif
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL or_drain: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_and_single();
        in_valid = 1'b1; in_data = 4'b1011; in_last = 1'b1; op = 2'b01;
        #1;
        n_checks++;
        if (slice_a !== 4'b1111 || slice_b !== 4'b1011) begin
            n_fail++; $display("FAIL and_operands: got a=%b b=%b want 1111 1011", slice_a, slice_b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_count !== 8'd1 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL and_result: got vld=%b data=%b cnt=%0d err=%b want 1 1011 1 0", out_valid, out_data, out_count, out_err);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_xor_hold();
        logic stable;
        send(4'b1111, 1'b0, 2'b10, 0);
        // op port changes mid-packet must be ignored
        send(4'b1010, 1'b0, 2'b00, 2);
        send(4'b0110, 1'b1, 2'b01, 3);
        stable = 1'b1;
        // keep a word waiting during HOLD; it must not be taken early
        in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b1; op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 4'b0011 || out_count !== 8'd3 || in_ready !== 1'b0)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!stable || out_data !== 4'b0011) begin
            n_fail++; $display("FAIL xor_hold: got data=%b cnt=%0d rdy=%b stable=%b want 0011 3 0 1",
                               out_data, out_count, in_ready, stable);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL xor_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1111 || out_count !== 8'd1) begin
            n_fail++; $display("FAIL next_after_hold: got vld=%b data=%b cnt=%0d want 1 1111 1", out_valid, out_data, out_count);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_rsvd();
        send(4'b0101, 1'b0, 2'b11, 0);
        send(4'b0101, 1'b1, 2'b11, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0000 || out_err !== 1'b1 || out_count !== 8'd2) begin
            n_fail++; $display("FAIL rsvd_result: got vld=%b data=%b err=%b cnt=%0d want 1 0000 1 2", out_valid, out_data, out_err, out_count);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        send(4'b0010, 1'b1, 2'b00, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0010 || out_err !== 1'b0 || out_count !== 8'd1) begin
            n_fail++; $display("FAIL after_rsvd: got vld=%b data=%b err=%b cnt=%0d want 1 0010 0 1", out_valid, out_data, out_err, out_count);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset_midpacket();
        logic seen;
        send(4'b0001, 1'b0, 2'b00, 0);
        send(4'b0100, 1'b0, 2'b00, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_no_valid: got out_valid=1 want 0"); end
        send(4'b0001, 1'b1, 2'b00, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0001 || out_count !== 8'd1) begin
            n_fail++; $display("FAIL after_midreset: got vld=%b data=%b cnt=%0d want 1 0001 1", out_valid, out_data, out_count);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [WIDTH-1:0] w[$];
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 300; i++) begin
            d = (i < 290) ? 4'b0000 : WIDTH'($urandom_range(0, 15));
            w.push_back(d);
            send(d, (i == 299), 2'b00, 0);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 8'(ref_count(300)) || out_data !== ref_reduce(2'b00, w)) begin
            n_fail++; $display("FAIL saturation: got vld=%b cnt=%0d data=%b want 1 255 %b",
                               out_valid, out_count, out_data, ref_reduce(2'b00, w));
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] w[$];
        logic [WIDTH-1:0] d, exp_d;
        logic [1:0] o;
        int len, wait_c;
        logic ok;
        for (int p = 0; p < 30; p++) begin
            w.delete();
            o = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                d = WIDTH'($urandom_range(0, 15));
                w.push_back(d);
                // later beats carry a random op that must be ignored
                send(d, (i == len - 1), (i == 0) ? o : 2'($urandom_range(0, 3)), $urandom_range(0, 2));
            end
            exp_d = ref_reduce(o, w);
            wait_c = $urandom_range(0, 3);
            ok = 1'b1;
            for (int c = 0; c <= wait_c; c++) begin
                if (out_valid !== 1'b1 || out_data !== exp_d || out_count !== 8'(ref_count(len)) ||
                    out_err !== (o == 2'b11) || in_ready !== 1'b0)
                    ok = 1'b0;
`ifdef LOGIC_REDUCE_PARITY_EN
                if (out_parity !== ^exp_d) ok = 1'b0;
`endif
                if (c < wait_c) begin @(posedge clk); #1; end
            end
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL random_pkt%0d: got vld=%b data=%b cnt=%0d err=%b want 1 %b %0d %b",
                                   p, out_valid, out_data, out_count, out_err, exp_d, len, (o == 2'b11));
            end
            out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL random_drain%0d: got vld=%b want 0", p, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_or_packet();
        test_and_single();
        test_xor_hold();
        test_rsvd();
        test_reset_midpacket();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
